gem_ext_fifo_rx_pkt: RTL and testbench
======================================

GEM_EXT_FIFO_RX_PKT -- requirements
Module: gem_ext_fifo_rx_pkt

Interface
REQ-001 Parameter DEPTH_LOG2, default 11, log2 of the frame buffer depth in bytes (2048).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 i_data  input  8  received byte from the upstream GEM external-FIFO RX stage.
REQ-005 i_valid  input  1  i_data carries a byte this cycle.
REQ-006 i_start  input  1  byte is the first of a frame; qualified by i_valid.
REQ-007 i_end  input  1  byte is the last of a frame; qualified by i_valid.
REQ-008 i_abort  input  1  upstream error or overflow; the current frame is invalid; not qualified by i_valid.
REQ-009 o_tdata  output  8  stored byte.
REQ-010 o_tvalid  output  1  o_tdata, o_tlast valid.
REQ-011 o_tlast  output  1  last byte of a frame.
REQ-012 i_tready  input  1  consumer accepts the byte.
REQ-013 o_drop  output  1  one-cycle pulse per discarded frame.

Function
REQ-014 Storage SHALL be 2^DEPTH_LOG2 entries of 9 bits: data plus end flag.
REQ-015 Pointers wr_ptr, commit_ptr and rd_ptr SHALL be DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
REQ-016 Full SHALL be defined as wr_ptr - rd_ptr == 2^DEPTH_LOG2; empty SHALL be defined as rd_ptr == commit_ptr.
REQ-017 The write FSM SHALL have the states IDLE, WRITE and DROP.
- IDLE: a byte with i_valid and i_start is written and the FSM goes to WRITE; bytes without i_start are ignored.
- WRITE: each i_valid byte is written at wr_ptr and wr_ptr increments.
- WRITE with i_end: commit_ptr <= wr_ptr+1 and the FSM goes to IDLE.
REQ-018 i_start and i_end in the same cycle SHALL commit a 1-byte frame with its end flag set.
REQ-019 In WRITE, i_abort, or i_valid while full, SHALL:
- rewind wr_ptr to commit_ptr;
- pulse o_drop;
- move the FSM to DROP; an abort-causing byte is not written.
REQ-020 DROP SHALL discard bytes until i_valid&&i_end, then go to IDLE; i_valid&&i_start in DROP starts a new frame, as in IDLE.
REQ-021 A byte with i_valid and i_start while in WRITE (missing end) SHALL discard the partial frame, pulse o_drop, and begin a new frame with that byte.
REQ-022 A new frame arriving while full in IDLE SHALL be dropped at its first byte (o_drop pulse, DROP state).
REQ-023 Only committed bytes SHALL be visible to the read side; a partial frame is never output.
REQ-024 The read side SHALL be a registered output stage.
- o_tvalid rises no earlier than 2 cycles after the commit edge.
- When o_tvalid=1, o_tdata and o_tlast hold until i_tready=1.
- Throughput is 1 byte/cycle with i_tready held high.
REQ-025 Simultaneous write, commit, rewind and read SHALL be handled in the same cycle without loss; a rewind never moves wr_ptr behind rd_ptr.

Reset
REQ-026 While resetn=0, the block SHALL force:
- FSM=IDLE;
- all pointers=0;
- o_tvalid=0, o_tlast=0, o_tdata=8'h00, o_drop=0.
Storage contents SHALL not be reset.
REQ-027 Reset mid-frame SHALL lose all buffered and partial frames; after release the block waits for the next i_start.

Configuration
REQ-028 Macro GEM_EXT_FIFO_RX_PKT_STATS_EN. When it is defined, the block SHALL add the following outputs:
- o_frame_cnt [31:0]: increments per committed frame;
- o_drop_cnt [31:0]: increments per o_drop pulse.
Both counters wrap at 2^32 and reset to 0. When the macro is undefined, these ports and counters SHALL not exist and behaviour is otherwise identical.

Verification
REQ-029 Single frame: 64-byte frame 0x00..0x3F, i_tready=1 -> 64 bytes out in order, o_tlast only on 0x3F, no o_drop.
REQ-030 Abort mid-frame: 10 bytes then i_abort, then a 5-byte frame 0xA0..0xA4 -> one o_drop pulse, output is only 0xA0..0xA4.
REQ-031 Overflow: DEPTH_LOG2=4, i_tready=0, 10-byte frame committed, then a 10-byte frame -> second frame dropped at byte 7, o_drop=1; after draining, the first frame is intact.
REQ-032 Back-pressure: 3-byte frame, i_tready toggling 1,0,0,1,... -> o_tdata stable while stalled, 3 bytes delivered exactly once.
REQ-033 Edge cases: 1-byte frame (i_start=i_end=1, 0x5A) followed by start-without-end then a new start -> 0x5A with o_tlast, one o_drop, second frame delivered.
REQ-034 Reset mid-output: assert resetn=0 during a read burst -> o_tvalid=0 immediately (asynchronous), counters=0 with GEM_EXT_FIFO_RX_PKT_STATS_EN defined.

Source files
------------

// File: rtl/gem_ext_fifo_rx_pkt_if.sv
// Byte-stream bundle between the GEM external-FIFO RX stage, the frame buffer and its consumer.
// slave = frame buffer side, master = upstream source plus downstream sink.
interface gem_ext_fifo_rx_pkt_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_start;
    logic       i_end;
    logic       i_abort;
    logic [7:0] o_tdata;
    logic       o_tvalid;
    logic       o_tlast;
    logic       i_tready;
    logic       o_drop;

    modport slave (
        input  i_data, i_valid, i_start, i_end, i_abort, i_tready,
        output o_tdata, o_tvalid, o_tlast, o_drop
    );

    modport master (
        output i_data, i_valid, i_start, i_end, i_abort, i_tready,
        input  o_tdata, o_tvalid, o_tlast, o_drop
    );
endinterface

// File: rtl/gem_ext_fifo_rx_pkt.sv
// Store-and-forward RX frame buffer: only fully received frames reach the output stream.
// Latency: o_tvalid two cycles after the commit edge. Backpressure: i_tready stalls output; input has none, frames are dropped when full.
// Optional GEM_EXT_FIFO_RX_PKT_STATS_EN adds o_frame_cnt / o_drop_cnt.
module gem_ext_fifo_rx_pkt #(
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                   clk,
    input  logic                   resetn,
    gem_ext_fifo_rx_pkt_if.slave   bus
`ifdef GEM_EXT_FIFO_RX_PKT_STATS_EN
    ,
    output logic [31:0]            o_frame_cnt,
    output logic [31:0]            o_drop_cnt
`endif
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [PW-1:0] ptr_t;
    typedef enum logic [1:0] {IDLE, WRITE, DROP} wstate_t;

    logic [8:0] mem [DEPTH];

    wstate_t state, nstate;
    ptr_t    wr_ptr, commit_ptr, rd_ptr, fetch_ptr, wr_base;
    ptr_t    wr_fill, commit_fill;
    logic    wr_full, commit_full;
    logic    we, rewind, drop, commit;

    // rd_ptr only moves on a consumer handshake, so bytes parked in the output
    // pipeline still occupy buffer space; fetch_ptr runs ahead to feed that pipeline.
    assign wr_fill     = wr_ptr - rd_ptr;
    assign commit_fill = commit_ptr - rd_ptr;
    assign wr_full     = (wr_fill == ptr_t'(DEPTH));
    assign commit_full = (commit_fill == ptr_t'(DEPTH));

    always_comb begin
        we     = 1'b0;
        rewind = 1'b0;
        drop   = 1'b0;
        commit = 1'b0;
        nstate = state;
        case (state)
            WRITE: begin
                if (bus.i_abort) begin
                    rewind = 1'b1;
                    drop   = 1'b1;
                    nstate = DROP;
                end else if (bus.i_valid && bus.i_start) begin
                    // Missing end: discard the partial frame and restart at commit_ptr.
                    rewind = 1'b1;
                    drop   = 1'b1;
                    if (commit_full) begin
                        nstate = bus.i_end ? IDLE : DROP;
                    end else begin
                        we     = 1'b1;
                        commit = bus.i_end;
                        nstate = bus.i_end ? IDLE : WRITE;
                    end
                end else if (bus.i_valid && wr_full) begin
                    rewind = 1'b1;
                    drop   = 1'b1;
                    nstate = bus.i_end ? IDLE : DROP;
                end else if (bus.i_valid) begin
                    we     = 1'b1;
                    commit = bus.i_end;
                    nstate = bus.i_end ? IDLE : WRITE;
                end
            end
            default: begin
                if (bus.i_valid && bus.i_start) begin
                    if (wr_full) begin
                        drop   = 1'b1;
                        nstate = bus.i_end ? IDLE : DROP;
                    end else begin
                        we     = 1'b1;
                        commit = bus.i_end;
                        nstate = bus.i_end ? IDLE : WRITE;
                    end
                end else if (bus.i_valid && bus.i_end) begin
                    nstate = IDLE;
                end
            end
        endcase
    end

    assign wr_base = rewind ? commit_ptr : wr_ptr;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_base[DEPTH_LOG2-1:0]] <= {bus.i_end, bus.i_data};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            bus.o_drop <= 1'b0;
        end else begin
            state      <= nstate;
            wr_ptr     <= we ? wr_base + ptr_t'(1) : wr_base;
            bus.o_drop <= drop;
            if (commit) begin
                commit_ptr <= wr_base + ptr_t'(1);
            end
        end
    end

    // Read side: registered memory read stage followed by the registered output stage.
    logic       s1_vld;
    logic [8:0] s1_dat;
    logic       out_rdy, s1_en, fetch;

    assign out_rdy = !bus.o_tvalid || bus.i_tready;
    assign s1_en   = !s1_vld || out_rdy;
    assign fetch   = s1_en && (fetch_ptr != commit_ptr);

    always_ff @(posedge clk) begin
        if (fetch) begin
            s1_dat <= mem[fetch_ptr[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_ptr    <= '0;
            rd_ptr       <= '0;
            s1_vld       <= 1'b0;
            bus.o_tvalid <= 1'b0;
            bus.o_tlast  <= 1'b0;
            bus.o_tdata  <= 8'h00;
        end else begin
            if (s1_en) begin
                s1_vld <= fetch;
            end
            if (fetch) begin
                fetch_ptr <= fetch_ptr + ptr_t'(1);
            end
            if (out_rdy) begin
                bus.o_tvalid <= s1_vld;
                if (s1_vld) begin
                    {bus.o_tlast, bus.o_tdata} <= s1_dat;
                end
            end
            if (bus.o_tvalid && bus.i_tready) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

`ifdef GEM_EXT_FIFO_RX_PKT_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_frame_cnt <= '0;
            o_drop_cnt  <= '0;
        end else begin
            if (commit) begin
                o_frame_cnt <= o_frame_cnt + 32'd1;
            end
            if (drop) begin
                o_drop_cnt <= o_drop_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_gem_ext_fifo_rx_pkt.sv
// Bench for gem_ext_fifo_rx_pkt: a default-depth instance for stream behaviour and a 16-byte instance for overflow.
`define CHK(TAG, GOT, EXP) \
    begin \
        checks++; \
        assert ((GOT) === (EXP)) else begin \
            errors++; \
            $error("FAIL %s: got %0h expected %0h", TAG, (GOT), (EXP)); \
        end \
    end

module tb_gem_ext_fifo_rx_pkt;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;

    int checks = 0;
    int errors = 0;

    gem_ext_fifo_rx_pkt_if a_if ();
    gem_ext_fifo_rx_pkt_if b_if ();

`ifdef GEM_EXT_FIFO_RX_PKT_STATS_EN
    logic [31:0] a_fcnt, a_dcnt, b_fcnt, b_dcnt;
`endif

    gem_ext_fifo_rx_pkt dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (a_if.slave)
`ifdef GEM_EXT_FIFO_RX_PKT_STATS_EN
        ,
        .o_frame_cnt (a_fcnt),
        .o_drop_cnt  (a_dcnt)
`endif
    );

    gem_ext_fifo_rx_pkt #(.DEPTH_LOG2(4)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (b_if.slave)
`ifdef GEM_EXT_FIFO_RX_PKT_STATS_EN
        ,
        .o_frame_cnt (b_fcnt),
        .o_drop_cnt  (b_dcnt)
`endif
    );

    // Reference model: committed frames in arrival order, plus frame/drop tallies.
    logic [8:0] exp_a[$], got_a[$], exp_b[$], got_b[$];
    int exp_frames_a = 0, exp_drops_a = 0, drops_a = 0;
    int exp_frames_b = 0, exp_drops_b = 0, drops_b = 0;

    int   tr_mode_a = 0;
    logic tr_fix_a  = 1'b1;
    int   pc_a      = 0;
    logic tr_b      = 1'b1;

    logic       stall_a = 1'b0, stall_b = 1'b0;
    logic [8:0] hold_a, hold_b;

    always @(negedge clk) begin
        if (stall_a && resetn === 1'b1) begin
            checks++;
            assert (a_if.o_tvalid === 1'b1 && {a_if.o_tlast, a_if.o_tdata} === hold_a) else begin
                errors++;
                $error("FAIL hold_a: got v=%0b d=%0h expected v=1 d=%0h", a_if.o_tvalid, {a_if.o_tlast, a_if.o_tdata}, hold_a);
            end
        end
        if (a_if.o_tvalid === 1'b1 && a_if.i_tready === 1'b1) got_a.push_back({a_if.o_tlast, a_if.o_tdata});
        if (a_if.o_drop === 1'b1) drops_a++;
        stall_a = (a_if.o_tvalid === 1'b1) && (a_if.i_tready === 1'b0);
        hold_a  = {a_if.o_tlast, a_if.o_tdata};
    end

    always @(negedge clk) begin
        if (stall_b && resetn === 1'b1) begin
            checks++;
            assert (b_if.o_tvalid === 1'b1 && {b_if.o_tlast, b_if.o_tdata} === hold_b) else begin
                errors++;
                $error("FAIL hold_b: got v=%0b d=%0h expected v=1 d=%0h", b_if.o_tvalid, {b_if.o_tlast, b_if.o_tdata}, hold_b);
            end
        end
        if (b_if.o_tvalid === 1'b1 && b_if.i_tready === 1'b1) got_b.push_back({b_if.o_tlast, b_if.o_tdata});
        if (b_if.o_drop === 1'b1) drops_b++;
        stall_b = (b_if.o_tvalid === 1'b1) && (b_if.i_tready === 1'b0);
        hold_b  = {b_if.o_tlast, b_if.o_tdata};
    end

    function automatic logic ready_a();
        logic r;
        case (tr_mode_a)
            0:       r = tr_fix_a;
            1:       r = 1'($urandom_range(0, 1));
            default: r = ((pc_a % 4) == 0) || ((pc_a % 4) == 3);
        endcase
        pc_a++;
        return r;
    endfunction

    task automatic step_a(input logic v, input logic s, input logic e, input logic ab, input logic [7:0] d);
        a_if.i_valid  = v;
        a_if.i_start  = s;
        a_if.i_end    = e;
        a_if.i_abort  = ab;
        a_if.i_data   = d;
        a_if.i_tready = ready_a();
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v, input logic s, input logic e, input logic ab, input logic [7:0] d);
        b_if.i_valid  = v;
        b_if.i_start  = s;
        b_if.i_end    = e;
        b_if.i_abort  = ab;
        b_if.i_data   = d;
        b_if.i_tready = tr_b;
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = complete frame, 1 = aborted after len bytes, 2 = no end byte (next start restarts)
    task automatic frame_a(input int len, input logic [7:0] base, input int kind, input logic rnd);
        logic [7:0] d;
        logic       last;
        for (int i = 0; i < len; i++) begin
            d    = rnd ? 8'($urandom) : 8'(base + i);
            last = (kind == 0) && (i == len - 1);
            step_a(1'b1, i == 0, last, 1'b0, d);
            if (kind == 0) exp_a.push_back({last, d});
        end
        if (kind == 1) step_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        if (kind == 0) exp_frames_a++;
        else exp_drops_a++;
    endtask

    task automatic drain_a(input int budget, output int n);
        n = 0;
        while (got_a.size() < exp_a.size() && n < budget) begin
            step_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            n++;
        end
        repeat (8) step_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_a(input string tag);
        `CHK({tag, "_count"}, got_a.size(), exp_a.size())
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            `CHK({tag, "_byte"}, got_a[i], exp_a[i])
        end
        `CHK({tag, "_drops"}, drops_a, exp_drops_a)
`ifdef GEM_EXT_FIFO_RX_PKT_STATS_EN
        `CHK({tag, "_frame_cnt"}, a_fcnt, 32'(exp_frames_a))
        `CHK({tag, "_drop_cnt"}, a_dcnt, 32'(exp_drops_a))
`endif
        got_a.delete();
        exp_a.delete();
    endtask

    initial begin
        int n;
        int drop_at;
        logic [7:0] d;

        resetn = 1'b0;
        {a_if.i_valid, a_if.i_start, a_if.i_end, a_if.i_abort} = 4'b0;
        {b_if.i_valid, b_if.i_start, b_if.i_end, b_if.i_abort} = 4'b0;
        a_if.i_data = 8'h00;
        b_if.i_data = 8'h00;
        b_if.i_tready = 1'b1;
        repeat (3) step_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        `CHK("rst_tvalid_a", a_if.o_tvalid, 1'b0)
        `CHK("rst_tlast_a", a_if.o_tlast, 1'b0)
        `CHK("rst_tdata_a", a_if.o_tdata, 8'h00)
        `CHK("rst_drop_a", a_if.o_drop, 1'b0)
        `CHK("rst_tvalid_b", b_if.o_tvalid, 1'b0)
        `CHK("rst_drop_b", b_if.o_drop, 1'b0)
        resetn = 1'b1;
        repeat (2) step_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // 64-byte frame at full rate: in order, tlast on the final byte, 1 byte/cycle.
        frame_a(64, 8'h00, 0, 1'b0);
        drain_a(400, n);
        `CHK("single_rate", (n <= 66), 1'b1)
        check_a("single");

        // Abort after 10 bytes, then a clean 5-byte frame.
        frame_a(10, 8'h30, 1, 1'b0);
        frame_a(5, 8'hA0, 0, 1'b0);
        drain_a(400, n);
        check_a("abort");

        // Consumer stalls with ready pattern 1,0,0,1.
        tr_mode_a = 2;
        frame_a(3, 8'hC0, 0, 1'b0);
        drain_a(400, n);
        check_a("bp");

        // 1-byte frame, start without end, then a fresh frame.
        tr_mode_a = 0;
        tr_fix_a  = 1'b1;
        frame_a(1, 8'h5A, 0, 1'b0);
        frame_a(3, 8'h60, 2, 1'b0);
        frame_a(4, 8'h70, 0, 1'b0);
        drain_a(400, n);
        check_a("edge");

        // Random frames, aborts, missing ends, junk bytes and random ready.
        tr_mode_a = 1;
        for (int f = 0; f < 30; f++) begin
            int r, kind, len;
            r    = $urandom_range(0, 9);
            kind = (f == 29 || r < 6) ? 0 : ((r < 8) ? 1 : 2);
            len  = $urandom_range(1, 24);
            frame_a(len, 8'h00, kind, 1'b1);
            if (kind != 2) begin
                repeat ($urandom_range(0, 3)) begin
                    d = 8'($urandom);
                    step_a(1'b1, 1'b0, 1'b0, 1'b0, d);
                end
            end
        end
        drain_a(3000, n);
        check_a("random");

        // Overflow on the 16-byte instance with the consumer stalled.
        tr_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_b(1'b1, i == 0, i == 9, 1'b0, 8'(8'h10 + i));
            exp_b.push_back({i == 9, 8'(8'h10 + i)});
        end
        exp_frames_b++;
        step_b(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        drop_at = (1 << 4) - 10 + 1;
        for (int i = 0; i < 10; i++) begin
            step_b(1'b1, i == 0, i == 9, 1'b0, 8'(8'h20 + i));
            `CHK("ovf_drop_pulse", b_if.o_drop, (i + 1 == drop_at))
        end
        exp_drops_b++;
        tr_b = 1'b1;
        n = 0;
        while (got_b.size() < exp_b.size() && n < 200) begin
            step_b(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            n++;
        end
        repeat (8) step_b(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        `CHK("ovf_count", got_b.size(), exp_b.size())
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            `CHK("ovf_byte", got_b[i], exp_b[i])
        end
        `CHK("ovf_drops", drops_b, exp_drops_b)
`ifdef GEM_EXT_FIFO_RX_PKT_STATS_EN
        `CHK("ovf_frame_cnt", b_fcnt, 32'(exp_frames_b))
        `CHK("ovf_drop_cnt", b_dcnt, 32'(exp_drops_b))
`endif

        // Reset in the middle of an output burst with a partial frame being written.
        tr_mode_a = 0;
        tr_fix_a  = 1'b0;
        frame_a(30, 8'h80, 0, 1'b0);
        tr_fix_a = 1'b1;
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'hF0);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'hF1);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'hF2);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'hF3);
        {a_if.i_valid, a_if.i_start, a_if.i_end, a_if.i_abort} = 4'b0;
        `CHK("pre_rst_tvalid", a_if.o_tvalid, 1'b1)
        #3 resetn = 1'b0;
        #1;
        `CHK("midrst_tvalid", a_if.o_tvalid, 1'b0)
        `CHK("midrst_tlast", a_if.o_tlast, 1'b0)
        `CHK("midrst_tdata", a_if.o_tdata, 8'h00)
        `CHK("midrst_drop", a_if.o_drop, 1'b0)
`ifdef GEM_EXT_FIFO_RX_PKT_STATS_EN
        `CHK("midrst_frame_cnt", a_fcnt, 32'd0)
        `CHK("midrst_drop_cnt", a_dcnt, 32'd0)
`endif
        exp_a.delete();
        exp_frames_a = 0;
        exp_drops_a  = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        got_a.delete();
        drops_a = 0;
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'hF4);
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 8'hF5);
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        frame_a(4, 8'hE0, 0, 1'b0);
        drain_a(400, n);
        check_a("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
